// File: rtl/dispatch_queue.sv
// ============================================================================
// Module   : dispatch_queue
// Brief    : In-order dispatch buffer between decode and RS/LSB/ROB-only paths,
//            with per-operand CDB wake-up snooping and issue-time CDB bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dispatch_queue #(
   parameter int DEPTH = 4,
   parameter int ROB_W = 4,
   parameter int N_CDB = 2,
   parameter int OPT_W = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      clear,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                in_target,
   input  logic [OPT_W-1:0]          in_opt,
   input  logic [ROB_W-1:0]          in_rob,
   input  logic [31:0]               in_vj,
   input  logic [31:0]               in_vk,
   input  logic [ROB_W:0]            in_qj,
   input  logic [ROB_W:0]            in_qk,
   input  logic [N_CDB-1:0]          cdb_ok,
   input  logic [N_CDB*ROB_W-1:0]    cdb_en,
   input  logic [N_CDB*32-1:0]       cdb_val,
   input  logic                      rs_full,
   input  logic                      lsb_full,
   output logic                      out_valid,
   output logic [1:0]                out_target,
   output logic [OPT_W-1:0]          out_opt,
   output logic [ROB_W-1:0]          out_rob,
   output logic [31:0]               out_vj,
   output logic [31:0]               out_vk,
   output logic [ROB_W:0]            out_qj,
   output logic [ROB_W:0]            out_qk,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ROB_W:0]  c_ready = {1'b1, {ROB_W{1'b0}}};
   localparam logic [CW-1:0]   c_full  = CW'(DEPTH);

   logic [DEPTH-1:0]   r_valid;
   logic [1:0]         r_target [DEPTH];
   logic [OPT_W-1:0]   r_opt    [DEPTH];
   logic [ROB_W-1:0]   r_rob    [DEPTH];
   logic [31:0]        r_vj     [DEPTH];
   logic [31:0]        r_vk     [DEPTH];
   logic [ROB_W:0]     r_qj     [DEPTH];
   logic [ROB_W:0]     r_qk     [DEPTH];
   logic [PW-1:0]      r_head;
   logic [PW-1:0]      r_tail;
   logic [CW-1:0]      r_count;

   logic               w_full;
   logic               w_empty;
   logic               w_push;
   logic               w_unit_ok;
   logic               w_issue;
   logic [ROB_W+32:0]  w_in_j;
   logic [ROB_W+32:0]  w_in_k;
   logic [ROB_W+32:0]  w_head_j;
   logic [ROB_W+32:0]  w_head_k;

   // Returns {tag, value} after applying any matching broadcast; the scan runs
   // from the top channel down so the lowest-indexed match is the one kept.
   function automatic logic [ROB_W+32:0] wake(input logic [ROB_W:0] q,
                                              input logic [31:0]    v);
      logic [ROB_W+32:0] res;
      res = {q, v};
      for (int i = N_CDB - 1; i >= 0; i--) begin
         if (q != c_ready && cdb_ok[i] && cdb_en[i*ROB_W +: ROB_W] == q[ROB_W-1:0])
            res = {c_ready, cdb_val[i*32 +: 32]};
      end
      return res;
   endfunction

   assign w_full   = (r_count == c_full);
   assign w_empty  = (r_count == '0);
   assign in_ready = !rst && rdy && !clear && !w_full;
   assign w_push   = in_valid && in_ready;

   always_comb begin
      w_unit_ok = 1'b1;
      case (r_target[r_head])
         2'd1:    w_unit_ok = !rs_full;
         2'd2:    w_unit_ok = !lsb_full;
         default: w_unit_ok = 1'b1;
      endcase
   end

   assign w_issue  = !rst && rdy && !clear && !w_empty && w_unit_ok;

   always_comb begin
      w_in_j   = wake(in_qj, in_vj);
      w_in_k   = wake(in_qk, in_vk);
      w_head_j = wake(r_qj[r_head], r_vj[r_head]);
      w_head_k = wake(r_qk[r_head], r_vk[r_head]);
   end

   assign out_valid  = w_issue;
   assign out_target = w_issue ? r_target[r_head]        : '0;
   assign out_opt    = w_issue ? r_opt[r_head]           : '0;
   assign out_rob    = w_issue ? r_rob[r_head]           : '0;
   assign out_vj     = w_issue ? w_head_j[31:0]          : '0;
   assign out_vk     = w_issue ? w_head_k[31:0]          : '0;
   assign out_qj     = w_issue ? w_head_j[ROB_W+32:32]   : '0;
   assign out_qk     = w_issue ? w_head_k[ROB_W+32:32]   : '0;
   assign count      = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
      end else if (rdy) begin
         if (clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (r_valid[i]) begin
                  {r_qj[i], r_vj[i]} <= wake(r_qj[i], r_vj[i]);
                  {r_qk[i], r_vk[i]} <= wake(r_qk[i], r_vk[i]);
               end
            end
            if (w_issue) begin
               r_valid[r_head] <= 1'b0;
               r_head          <= r_head + 1'b1;
            end
            // Never aliases the head slot: a push requires !full.
            if (w_push) begin
               r_valid[r_tail]                <= 1'b1;
               r_target[r_tail]               <= in_target;
               r_opt[r_tail]                  <= in_opt;
               r_rob[r_tail]                  <= in_rob;
               {r_qj[r_tail], r_vj[r_tail]}   <= w_in_j;
               {r_qk[r_tail], r_vk[r_tail]}   <= w_in_k;
               r_tail                         <= r_tail + 1'b1;
            end
            case ({w_push, w_issue})
               2'b10:   r_count <= r_count + 1'b1;
               2'b01:   r_count <= r_count - 1'b1;
               default: r_count <= r_count;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dispatch_queue.sv
// ============================================================================
// Module   : tb_dispatch_queue
// Brief    : Self-checking bench for dispatch_queue: queue-based reference
//            model compared every cycle, directed scenarios and random traffic.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dispatch_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, rdy, clear, in_valid, in_ready;
   logic [1:0]  in_target;
   logic [5:0]  in_opt;
   logic [3:0]  in_rob;
   logic [31:0] in_vj, in_vk;
   logic [4:0]  in_qj, in_qk;
   logic [1:0]  cdb_ok;
   logic [7:0]  cdb_en;
   logic [63:0] cdb_val;
   logic        rs_full, lsb_full;
   logic        out_valid;
   logic [1:0]  out_target;
   logic [5:0]  out_opt;
   logic [3:0]  out_rob;
   logic [31:0] out_vj, out_vk;
   logic [4:0]  out_qj, out_qk;
   logic [2:0]  count;

   always #5 clk = ~clk;

   dispatch_queue #(.DEPTH(DEPTH), .ROB_W(4), .N_CDB(2), .OPT_W(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_target(in_target),
      .in_opt(in_opt), .in_rob(in_rob), .in_vj(in_vj), .in_vk(in_vk),
      .in_qj(in_qj), .in_qk(in_qk),
      .cdb_ok(cdb_ok), .cdb_en(cdb_en), .cdb_val(cdb_val),
      .rs_full(rs_full), .lsb_full(lsb_full),
      .out_valid(out_valid), .out_target(out_target), .out_opt(out_opt),
      .out_rob(out_rob), .out_vj(out_vj), .out_vk(out_vk),
      .out_qj(out_qj), .out_qk(out_qk), .count(count)
   );

   typedef struct packed {
      logic [1:0]  target;
      logic [5:0]  opt;
      logic [3:0]  rob;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [4:0]  qj;
      logic [4:0]  qk;
   } uop_t;

   uop_t mq[$];
   int   total = 0;
   int   bad   = 0;
   logic check_en = 1'b0;
   logic exp_valid, exp_ready;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // First matching channel in ascending order supplies the value.
   function automatic uop_t snoop(input uop_t u);
      for (int i = 0; i < 2; i++) begin
         if (u.qj != 5'd16 && cdb_ok[i] && cdb_en[i*4 +: 4] == u.qj[3:0]) begin
            u.vj = cdb_val[i*32 +: 32];
            u.qj = 5'd16;
         end
         if (u.qk != 5'd16 && cdb_ok[i] && cdb_en[i*4 +: 4] == u.qk[3:0]) begin
            u.vk = cdb_val[i*32 +: 32];
            u.qk = 5'd16;
         end
      end
      return u;
   endfunction

   function automatic uop_t in_uop();
      uop_t u;
      u.target = in_target; u.opt = in_opt; u.rob = in_rob;
      u.vj = in_vj; u.vk = in_vk; u.qj = in_qj; u.qk = in_qk;
      return u;
   endfunction

   task automatic settle();
      uop_t h;
      #1;
      exp_ready = !rst && rdy && !clear && (mq.size() < DEPTH);
      exp_valid = 1'b0;
      h = '0;
      if (!rst && rdy && !clear && mq.size() > 0) begin
         h = snoop(mq[0]);
         exp_valid = (h.target == 2'd1) ? !rs_full :
                     (h.target == 2'd2) ? !lsb_full : 1'b1;
      end
      if (!exp_valid) h = '0;
      if (check_en) begin
         chk("in_ready",   in_ready,   exp_ready);
         chk("out_valid",  out_valid,  exp_valid);
         chk("out_target", out_target, h.target);
         chk("out_opt",    out_opt,    h.opt);
         chk("out_rob",    out_rob,    h.rob);
         chk("out_vj",     out_vj,     h.vj);
         chk("out_vk",     out_vk,     h.vk);
         chk("out_qj",     out_qj,     h.qj);
         chk("out_qk",     out_qk,     h.qk);
         chk("count",      count,      mq.size());
      end
   endtask

   task automatic tick();
      uop_t n;
      @(posedge clk);
      if (rst) mq.delete();
      else if (rdy) begin
         if (clear) mq.delete();
         else begin
            n = snoop(in_uop());
            foreach (mq[i]) mq[i] = snoop(mq[i]);
            if (exp_valid) void'(mq.pop_front());
            if (in_valid && exp_ready) mq.push_back(n);
         end
      end
      @(negedge clk);
   endtask

   task automatic cyc();
      settle();
      tick();
   endtask

   task automatic idle();
      rst = 1'b0; rdy = 1'b1; clear = 1'b0; in_valid = 1'b0;
      in_target = 2'd0; in_opt = '0; in_rob = '0; in_vj = '0; in_vk = '0;
      in_qj = 5'd16; in_qk = 5'd16;
      cdb_ok = '0; cdb_en = '0; cdb_val = '0;
   endtask

   task automatic push(input logic [1:0] t, input logic [5:0] o,
                       input logic [4:0] qj, input logic [4:0] qk);
      in_valid = 1'b1; in_target = t; in_opt = o; in_rob = o[3:0];
      in_vj = 32'h100 + 32'(o); in_vk = 32'h200 + 32'(o);
      in_qj = qj; in_qk = qk;
   endtask

   initial begin
      idle();
      rs_full = 1'b0; lsb_full = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      check_en = 1'b1;

      // Reset state
      settle();
      chk("rst_count", count, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_opt", out_opt, 0);
      chk("rst_vj", out_vj, 0);
      tick();

      // Fill while RS is full, then drain in order
      rs_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         push(2'd1, 6'(8 + k), 5'd16, 5'd16);
         settle();
         if (k == 4) chk("full_ready", in_ready, 0);
         tick();
      end
      idle();
      settle();
      chk("full_count", count, 4);
      tick();
      rs_full = 1'b0;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("drain_valid", out_valid, 1);
         chk("drain_opt", out_opt, 6'(8 + k));
         tick();
      end
      settle();
      chk("drain_count", count, 0);
      tick();

      // Wake-up of a resident entry, then same-cycle issue bypass
      rs_full = 1'b1;
      push(2'd1, 6'h10, 5'd5, 5'd16);
      cyc();
      idle();
      cdb_ok = 2'b10; cdb_en = 8'h50; cdb_val = {32'hDEADBEEF, 32'h0};
      cyc();
      idle();
      rs_full = 1'b0;
      settle();
      chk("wake_vj", out_vj, 32'hDEADBEEF);
      chk("wake_qj", out_qj, 16);
      tick();
      rs_full = 1'b1;
      push(2'd1, 6'h11, 5'd5, 5'd16);
      cyc();
      idle();
      rs_full = 1'b0;
      cdb_ok = 2'b10; cdb_en = 8'h50; cdb_val = {32'hDEADBEEF, 32'h0};
      settle();
      chk("byp_valid", out_valid, 1);
      chk("byp_vj", out_vj, 32'hDEADBEEF);
      chk("byp_qj", out_qj, 16);
      tick();
      idle();

      // Snoop at push time, lowest channel priority
      rs_full = 1'b1;
      push(2'd1, 6'h12, 5'd16, 5'd3);
      cdb_ok = 2'b01; cdb_en = 8'h03; cdb_val = {32'h0, 32'h12};
      cyc();
      push(2'd1, 6'h13, 5'd16, 5'd3);
      cdb_ok = 2'b11; cdb_en = 8'h33; cdb_val = {32'h34, 32'h12};
      cyc();
      idle();
      rs_full = 1'b0;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("pushsnoop_vk", out_vk, 32'h12);
         chk("pushsnoop_qk", out_qk, 16);
         tick();
      end

      // Simultaneous push/pop, then head-of-line blocking
      rs_full = 1'b1; lsb_full = 1'b1;
      push(2'd2, 6'h14, 5'd16, 5'd16);
      cyc();
      push(2'd1, 6'h15, 5'd16, 5'd16);
      cyc();
      lsb_full = 1'b0;
      push(2'd1, 6'h16, 5'd16, 5'd16);
      settle();
      chk("pp_valid", out_valid, 1);
      chk("pp_target", out_target, 2);
      tick();
      idle();
      settle();
      chk("pp_count", count, 2);
      tick();
      rs_full = 1'b0;
      cyc();
      cyc();
      lsb_full = 1'b1;
      push(2'd2, 6'h17, 5'd16, 5'd16);
      cyc();
      push(2'd1, 6'h18, 5'd16, 5'd16);
      cyc();
      idle();
      settle();
      chk("hol_valid", out_valid, 0);
      chk("hol_count", count, 2);
      tick();
      lsb_full = 1'b0;
      cyc();
      cyc();

      // Flush with a concurrent push, then minimum latency
      rs_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         push(2'd1, 6'(6'h20 + k), 5'd16, 5'd16);
         cyc();
      end
      push(2'd1, 6'h3F, 5'd16, 5'd16);
      clear = 1'b1;
      settle();
      chk("clr_count_before", count, 3);
      chk("clr_valid", out_valid, 0);
      chk("clr_ready", in_ready, 0);
      tick();
      idle();
      rs_full = 1'b0;
      settle();
      chk("clr_count", count, 0);
      chk("clr_valid_after", out_valid, 0);
      tick();
      push(2'd1, 6'h2A, 5'd16, 5'd16);
      settle();
      chk("lat_noissue", out_valid, 0);
      tick();
      idle();
      settle();
      chk("lat_valid", out_valid, 1);
      chk("lat_opt", out_opt, 6'h2A);
      tick();

      // Random traffic against the model
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(99) == 0);
         rdy       = ($urandom_range(9) != 0);
         clear     = ($urandom_range(29) == 0);
         in_valid  = 1'($urandom_range(1));
         in_target = 2'($urandom_range(3));
         in_opt    = 6'($urandom);
         in_rob    = 4'($urandom);
         in_vj     = $urandom;
         in_vk     = $urandom;
         in_qj     = ($urandom_range(1) == 1) ? 5'd16 : 5'($urandom_range(3));
         in_qk     = ($urandom_range(1) == 1) ? 5'd16 : 5'($urandom_range(3));
         cdb_ok    = 2'($urandom_range(3));
         cdb_en    = {4'($urandom_range(3)), 4'($urandom_range(3))};
         cdb_val   = {$urandom, $urandom};
         rs_full   = ($urandom_range(2) == 0);
         lsb_full  = ($urandom_range(2) == 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
